// File: rtl/ps2_key_mapper.sv
// ps2_key_mapper: turns PS/2 Set 2 scan-code bytes into held-note state and
// one-cycle control strobes for the synth IO controller. Make, break (F0) and
// extended (E0) prefixes are tracked by a small FSM with a prefix timeout.
//
// Handshake: ps2_byte_valid is a one-cycle strobe with no backpressure; the
// byte is consumed on the rising edge where ps2_byte_valid is high, and every
// output reflects that byte right after the same edge (registered outputs).
module ps2_key_mapper #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_W      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_byte_valid,
    output logic       note_in,
    output logic [3:0] note,
    output logic       octave_plus_plus,
    output logic       octave_minus_minus,
    output logic       amp_plus_plus,
    output logic       amp_minus_minus,
    output logic [1:0] ADSR_selector,
    output logic       ADSR_plus_plus,
    output logic       ADSR_minus_minus
);

    localparam logic [7:0] LP_BRK = 8'hF0;
    localparam logic [7:0] LP_EXT = 8'hE0;
    localparam logic [TIMEOUT_W-1:0] LP_CNT_MAX = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic [TIMEOUT_W-1:0] w_cnt_nxt;

    logic       w_ignored;
    logic       w_accept;
    logic       w_expire;
    logic       w_do_make;
    logic       w_do_break;
    logic       w_do_ext;
    logic       w_is_note;
    logic [3:0] w_note_idx;

    logic       r_note_in;
    logic [3:0] r_note;
    logic       r_oct_pp;
    logic       r_oct_mm;
    logic       r_amp_pp;
    logic       r_amp_mm;
    logic [1:0] r_sel;
    logic       r_adsr_pp;
    logic       r_adsr_mm;

    // Keyboard housekeeping bytes (BAT ok, ACK, resend, echo, overrun) are
    // invisible to the decoder: they neither move the FSM nor clear the timer.
    assign w_ignored = (ps2_byte == 8'hAA) || (ps2_byte == 8'hFA) ||
                       (ps2_byte == 8'hFE) || (ps2_byte == 8'hEE) ||
                       (ps2_byte == 8'h00);
    assign w_accept  = ps2_byte_valid && !w_ignored;
    // A waiting prefix expires only on an empty cycle; a byte arriving on the
    // expiry cycle is decoded in the prefix state instead.
    assign w_expire  = (r_state != S_IDLE) && !ps2_byte_valid && (r_cnt == LP_CNT_MAX);

    // Map note scan codes to semitone index 0 (C) .. 11 (B).
    always_comb begin
        w_is_note  = 1'b1;
        w_note_idx = 4'd0;
        case (ps2_byte)
            8'h1C:   w_note_idx = 4'd0;
            8'h1D:   w_note_idx = 4'd1;
            8'h1B:   w_note_idx = 4'd2;
            8'h24:   w_note_idx = 4'd3;
            8'h23:   w_note_idx = 4'd4;
            8'h2B:   w_note_idx = 4'd5;
            8'h2C:   w_note_idx = 4'd6;
            8'h34:   w_note_idx = 4'd7;
            8'h35:   w_note_idx = 4'd8;
            8'h33:   w_note_idx = 4'd9;
            8'h3C:   w_note_idx = 4'd10;
            8'h3B:   w_note_idx = 4'd11;
            default: w_is_note  = 1'b0;
        endcase
    end

    // Prefix FSM next state and the kind of action the current byte triggers.
    always_comb begin
        w_state_nxt = r_state;
        w_do_make   = 1'b0;
        w_do_break  = 1'b0;
        w_do_ext    = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (ps2_byte == LP_BRK)      w_state_nxt = S_BRK;
                    else if (ps2_byte == LP_EXT) w_state_nxt = S_EXT;
                    else                         w_do_make   = 1'b1;
                end
                S_BRK: begin
                    if (ps2_byte == LP_BRK)      w_state_nxt = S_BRK;
                    else if (ps2_byte == LP_EXT) w_state_nxt = S_EXT;
                    else begin
                        w_do_break  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_EXT: begin
                    if (ps2_byte == LP_BRK)      w_state_nxt = S_EXT_BRK;
                    else if (ps2_byte == LP_EXT) w_state_nxt = S_EXT;
                    else begin
                        w_do_ext    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                // Extended breaks carry no action; just swallow the byte.
                S_EXT_BRK: w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end else if (w_expire) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Timeout counter: clears on accepted bytes and expiry, runs while a
    // prefix waits on an empty input.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_accept || w_expire)
            w_cnt_nxt = '0;
        else if ((r_state != S_IDLE) && !ps2_byte_valid)
            w_cnt_nxt = r_cnt + TIMEOUT_W'(1);
    end

    // FSM state and timeout counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Registered outputs: held note, selector, and single-cycle strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_note_in <= 1'b0;
            r_note    <= 4'd0;
            r_sel     <= 2'd0;
            r_oct_pp  <= 1'b0;
            r_oct_mm  <= 1'b0;
            r_amp_pp  <= 1'b0;
            r_amp_mm  <= 1'b0;
            r_adsr_pp <= 1'b0;
            r_adsr_mm <= 1'b0;
        end else begin
            r_oct_pp  <= 1'b0;
            r_oct_mm  <= 1'b0;
            r_amp_pp  <= 1'b0;
            r_amp_mm  <= 1'b0;
            r_adsr_pp <= 1'b0;
            r_adsr_mm <= 1'b0;
            if (w_do_make) begin
                // Last key pressed wins; a typematic repeat rewrites the same value.
                if (w_is_note) begin
                    r_note    <= w_note_idx;
                    r_note_in <= 1'b1;
                end
                case (ps2_byte)
                    8'h1A:   r_oct_mm <= 1'b1;
                    8'h22:   r_oct_pp <= 1'b1;
                    8'h4E:   r_amp_mm <= 1'b1;
                    8'h55:   r_amp_pp <= 1'b1;
                    8'h16:   r_sel    <= 2'd0;
                    8'h1E:   r_sel    <= 2'd1;
                    8'h26:   r_sel    <= 2'd2;
                    8'h25:   r_sel    <= 2'd3;
                    default: ;
                endcase
            end
            // Only releasing the sounding key silences it; note keeps its value.
            if (w_do_break && w_is_note && r_note_in && (w_note_idx == r_note))
                r_note_in <= 1'b0;
            if (w_do_ext) begin
                case (ps2_byte)
                    8'h75:   r_adsr_pp <= 1'b1;
                    8'h72:   r_adsr_mm <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign note_in            = r_note_in;
    assign note               = r_note;
    assign octave_plus_plus   = r_oct_pp;
    assign octave_minus_minus = r_oct_mm;
    assign amp_plus_plus      = r_amp_pp;
    assign amp_minus_minus    = r_amp_mm;
    assign ADSR_selector      = r_sel;
    assign ADSR_plus_plus     = r_adsr_pp;
    assign ADSR_minus_minus   = r_adsr_mm;

endmodule

// File: tb/tb_ps2_key_mapper.sv
// Testbench for ps2_key_mapper: scenario tasks driven byte-by-byte, every
// cycle compared against a keyboard-level reference model.
module tb_ps2_key_mapper;

    localparam int TO = 16;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ps2_byte;
    logic       ps2_byte_valid;
    logic       note_in;
    logic [3:0] note;
    logic       octave_plus_plus;
    logic       octave_minus_minus;
    logic       amp_plus_plus;
    logic       amp_minus_minus;
    logic [1:0] ADSR_selector;
    logic       ADSR_plus_plus;
    logic       ADSR_minus_minus;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ps2_key_mapper #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(5)) dut (
        .clk                (clk),
        .reset              (reset),
        .ps2_byte           (ps2_byte),
        .ps2_byte_valid     (ps2_byte_valid),
        .note_in            (note_in),
        .note               (note),
        .octave_plus_plus   (octave_plus_plus),
        .octave_minus_minus (octave_minus_minus),
        .amp_plus_plus      (amp_plus_plus),
        .amp_minus_minus    (amp_minus_minus),
        .ADSR_selector      (ADSR_selector),
        .ADSR_plus_plus     (ADSR_plus_plus),
        .ADSR_minus_minus   (ADSR_minus_minus)
    );

    logic [12:0] dut_vec;
    assign dut_vec = {note_in, note, octave_plus_plus, octave_minus_minus,
                      amp_plus_plus, amp_minus_minus, ADSR_selector,
                      ADSR_plus_plus, ADSR_minus_minus};

    // ---------------- reference model ----------------
    // Keyboard view: which prefixes have been seen, how long the prefix has
    // been waiting, and what the player currently hears / last pressed.
    logic       m_seen_e0, m_seen_f0;
    int         m_idle;
    logic       m_note_in;
    logic [3:0] m_note;
    logic [1:0] m_sel;
    logic [5:0] m_strobe;  // {oct+, oct-, amp+, amp-, adsr+, adsr-}

    logic [7:0] note_codes [12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                                    8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};

    function automatic int note_of(input logic [7:0] b);
        for (int i = 0; i < 12; i++)
            if (note_codes[i] == b) return i;
        return -1;
    endfunction

    function automatic logic is_housekeeping(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) || (b == 8'hEE) || (b == 8'h00);
    endfunction

    function automatic logic [12:0] exp_vec();
        return {m_note_in, m_note, m_strobe[5:2], m_sel, m_strobe[1:0]};
    endfunction

    task automatic model_reset();
        m_seen_e0 = 1'b0; m_seen_f0 = 1'b0; m_idle = 0;
        m_note_in = 1'b0; m_note = 4'd0; m_sel = 2'd0; m_strobe = '0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] b);
        int idx;
        m_strobe = '0;
        if (!v) begin
            if (m_seen_e0 || m_seen_f0) begin
                m_idle++;
                if (m_idle >= TO) begin
                    m_seen_e0 = 1'b0; m_seen_f0 = 1'b0; m_idle = 0;
                end
            end
            return;
        end
        if (is_housekeeping(b)) return;
        m_idle = 0;
        idx = note_of(b);
        if (m_seen_e0 && m_seen_f0) begin
            m_seen_e0 = 1'b0; m_seen_f0 = 1'b0;
        end else if (b == 8'hF0) begin
            m_seen_f0 = 1'b1;
        end else if (b == 8'hE0) begin
            m_seen_e0 = 1'b1; m_seen_f0 = 1'b0;
        end else begin
            if (m_seen_e0) begin
                if (b == 8'h75) m_strobe[1] = 1'b1;
                if (b == 8'h72) m_strobe[0] = 1'b1;
            end else if (m_seen_f0) begin
                if (idx >= 0 && m_note_in && idx == int'(m_note)) m_note_in = 1'b0;
            end else begin
                if (idx >= 0) begin m_note = 4'(idx); m_note_in = 1'b1; end
                case (b)
                    8'h22: m_strobe[5] = 1'b1;
                    8'h1A: m_strobe[4] = 1'b1;
                    8'h55: m_strobe[3] = 1'b1;
                    8'h4E: m_strobe[2] = 1'b1;
                    8'h16: m_sel = 2'd0;
                    8'h1E: m_sel = 2'd1;
                    8'h26: m_sel = 2'd2;
                    8'h25: m_sel = 2'd3;
                    default: ;
                endcase
            end
            m_seen_e0 = 1'b0; m_seen_f0 = 1'b0;
        end
    endtask

    // ---------------- driver ----------------
    // One clock cycle: present (v,b), update the model, settle after the edge.
    task automatic step(input logic v, input logic [7:0] b);
        @(negedge clk);
        ps2_byte_valid = v;
        ps2_byte       = b;
        model_step(v, b);
        @(posedge clk);
        #1;
        ps2_byte_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0; ps2_byte_valid = 1'b0; ps2_byte = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_vec !== 13'd0) begin
            errors++; $display("FAIL reset_state got=%h want=%h", dut_vec, 13'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 8'h00);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL reset_release got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_note_make_break();
        logic [7:0] seq [$] = '{8'h1C, 8'hF0, 8'h1C, 8'h1C, 8'h35, 8'hF0, 8'h1C, 8'hF0, 8'h35};
        foreach (seq[i]) begin
            step(1'b1, seq[i]);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL note_seq[%0d] byte=%h got=%h want=%h", i, seq[i], dut_vec, exp_vec());
            end
            if (i == 0 || i == 6) begin
                checks++;
                if ({note_in, note} !== {1'b1, (i == 0) ? 4'd0 : 4'd8}) begin
                    errors++; $display("FAIL note_held[%0d] got=%b/%0d", i, note_in, note);
                end
            end
            if (i == 2 || i == 8) begin
                checks++;
                if ({note_in, note} !== {1'b0, (i == 2) ? 4'd0 : 4'd8}) begin
                    errors++; $display("FAIL note_released[%0d] got=%b/%0d", i, note_in, note);
                end
            end
        end
    endtask

    task automatic test_typematic_control();
        int pulses = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'h22);
            pulses += int'(octave_plus_plus);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL oct_repeat[%0d] got=%h want=%h", k, dut_vec, exp_vec());
            end
            step(1'b0, 8'h00);
            pulses += int'(octave_plus_plus);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL oct_gap[%0d] got=%h want=%h", k, dut_vec, exp_vec());
            end
        end
        checks++;
        if (pulses != 3) begin
            errors++; $display("FAIL oct_pulse_count got=%0d want=3", pulses);
        end
        step(1'b1, 8'hF0);
        step(1'b1, 8'h22);
        checks++;
        if ({octave_plus_plus, octave_minus_minus, amp_plus_plus, amp_minus_minus,
             ADSR_plus_plus, ADSR_minus_minus} !== 6'b0) begin
            errors++; $display("FAIL control_break got=%h want=0", dut_vec);
        end
        foreach (note_codes[i]) begin
            logic [7:0] c [4] = '{8'h1A, 8'h4E, 8'h55, 8'h22};
            if (i < 4) begin
                step(1'b1, c[i]);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL ctrl_make byte=%h got=%h want=%h", c[i], dut_vec, exp_vec());
                end
            end
        end
    endtask

    task automatic test_adsr_ext();
        logic [7:0] seq [$] = '{8'h26, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75,
                                8'h25, 8'hE0, 8'h72, 8'hE0, 8'h1C, 8'h1E, 8'h16};
        int ups = 0;
        foreach (seq[i]) begin
            step(1'b1, seq[i]);
            if (i < 6) ups += int'(ADSR_plus_plus);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL adsr_seq[%0d] byte=%h got=%h want=%h", i, seq[i], dut_vec, exp_vec());
            end
            if (i == 5) begin
                checks++;
                if (ADSR_selector !== 2'd2 || ups != 1) begin
                    errors++; $display("FAIL adsr_plan sel=%0d ups=%0d want sel=2 ups=1", ADSR_selector, ups);
                end
            end
        end
    endtask

    task automatic test_timeout();
        // Plan case: stale F0 must expire so 1C is a fresh make.
        step(1'b1, 8'h35);
        step(1'b1, 8'hF0);
        repeat (TO) step(1'b0, 8'h00);
        step(1'b1, 8'h1C);
        checks++;
        if ({note_in, note} !== {1'b1, 4'd0}) begin
            errors++; $display("FAIL timeout_make got=%b/%0d want=1/0", note_in, note);
        end
        // One cycle short: byte arrives on the expiry cycle and is still a break.
        step(1'b1, 8'hF0);
        for (int k = 0; k < TO - 1; k++) begin
            step(1'b0, 8'h00);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL timeout_wait[%0d] got=%h want=%h", k, dut_vec, exp_vec());
            end
        end
        step(1'b1, 8'h1C);
        checks++;
        if (note_in !== 1'b0) begin
            errors++; $display("FAIL expiry_cycle_byte_wins got=%b want=0", note_in);
        end
        // Housekeeping byte neither clears the counter nor leaves the prefix.
        step(1'b1, 8'h1C);
        step(1'b1, 8'hF0);
        repeat (TO / 2) step(1'b0, 8'h00);
        step(1'b1, 8'hAA);
        repeat (TO / 2) step(1'b0, 8'h00);
        step(1'b1, 8'h1C);
        checks++;
        if ({note_in, dut_vec} !== {1'b1, exp_vec()}) begin
            errors++; $display("FAIL ignored_no_clear got=%h want=%h", dut_vec, exp_vec());
        end
        step(1'b1, 8'hF0);
        step(1'b1, 8'hFA);
        step(1'b1, 8'h1C);
        checks++;
        if (note_in !== 1'b0) begin
            errors++; $display("FAIL ignored_keeps_prefix got=%b want=0", note_in);
        end
    endtask

    task automatic test_reset_midseq();
        step(1'b1, 8'h24);
        checks++;
        if ({note_in, note} !== {1'b1, 4'd3}) begin
            errors++; $display("FAIL hold_24 got=%b/%0d want=1/3", note_in, note);
        end
        step(1'b1, 8'h26);
        step(1'b1, 8'hF0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== 13'd0) begin
            errors++; $display("FAIL async_reset got=%h want=0", dut_vec);
        end
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 8'h3C);
        checks++;
        if ({note_in, note} !== {1'b1, 4'd10} || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL after_reset_3C got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [$] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                                 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h1A, 8'h22,
                                 8'h4E, 8'h55, 8'h16, 8'h1E, 8'h26, 8'h25, 8'hF0,
                                 8'hF0, 8'hF0, 8'hE0, 8'hE0, 8'h75, 8'h72, 8'hAA,
                                 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'h5A, 8'h6B};
        for (int n = 0; n < 300; n++) begin
            logic [7:0] b;
            int gap;
            b = pool[$urandom_range(0, pool.size() - 1)];
            step(1'b1, b);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random[%0d] byte=%h got=%h want=%h", n, b, dut_vec, exp_vec());
            end
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 0;
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 8'h00);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL random_gap[%0d.%0d] got=%h want=%h", n, g, dut_vec, exp_vec());
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_note_make_break();
        test_typematic_control();
        test_adsr_ext();
        test_timeout();
        test_reset_midseq();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
